// File: rtl/ball_collision_detect.sv
// ball_collision_detect
//   Closes the Pong ball-control loop on the 240x320 LT24 frame. It watches
//   the ball position/direction and both paddle positions, and produces:
//   - single-cycle X/Y reverse pulses for the ball mover,
//   - miss detection with a one-cycle serve request,
//   - per-player scores and a sticky game-over flag.
//   All outputs are registered. Each pulse appears the cycle after the edge
//   at which its qualifying inputs were sampled.
//
// Optional feature (macro RALLY_COUNT_EN):
//   When defined, adds output rallyCount[7:0]. It counts changeXDirection
//   pulses, saturates at 255, and clears on reset and on every serveRequest.
//
// Ports:
//   clock             system clock
//   reset             synchronous, active-high reset
//   ballXValue[7:0]   ball left edge X
//   ballYValue[8:0]   ball top edge Y
//   direction         ball X direction, 1 = moving right
//   leftPaddleY[8:0]  left paddle top Y
//   rightPaddleY[8:0] right paddle top Y
//   changeXDirection  one-cycle pulse: reverse X
//   changeYDirection  one-cycle pulse: reverse Y
//   serveRequest      one-cycle pulse after a miss
//   leftScore         left player score
//   rightScore        right player score
//   gameOver          high once either score reaches WIN_SCORE
//   rallyCount[7:0]   paddle-hit count (only with RALLY_COUNT_EN)
module ball_collision_detect #(
    parameter int LEFT_PADDLE_X   = 10,
    parameter int RIGHT_PADDLE_X  = 219,
    parameter int PADDLE_LENGTH   = 50,
    parameter int BALL_SIZE       = 10,
    parameter int SCREEN_Y_MAX    = 319,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int WIN_SCORE       = 9,
    parameter int SCORE_WIDTH     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             ballXValue,
    input  logic [8:0]             ballYValue,
    input  logic                   direction,
    input  logic [8:0]             leftPaddleY,
    input  logic [8:0]             rightPaddleY,
    output logic                   changeXDirection,
    output logic                   changeYDirection,
    output logic                   serveRequest,
    output logic [SCORE_WIDTH-1:0] leftScore,
    output logic [SCORE_WIDTH-1:0] rightScore,
    output logic                   gameOver
`ifdef RALLY_COUNT_EN
    ,
    output logic [7:0]             rallyCount
`endif
);

    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [1:0] {
        PLAY,
        X_COOL,
        MISS,
        GAME_OVER
    } state_t;

    state_t                 state;
    logic [CW-1:0]          xcnt;
    logic [CW-1:0]          ycnt;

    // All geometry is evaluated 10 bits wide, zero-extended, so nothing wraps.
    logic [9:0]             ball_x;
    logic [9:0]             ball_y;
    logic [9:0]             ball_x_far;
    logic [9:0]             ball_y_far;
    logic [9:0]             lp_top;
    logic [9:0]             rp_top;
    logic [9:0]             lp_end;
    logic [9:0]             rp_end;
    logic                   at_right;
    logic                   at_left;
    logic                   overlap_left;
    logic                   overlap_right;
    logic                   y_wall;
    logic                   inside_field;
    logic [SCORE_WIDTH-1:0] left_next;
    logic [SCORE_WIDTH-1:0] right_next;

    always_comb begin
        ball_x        = {2'b00, ballXValue};
        ball_y        = {1'b0, ballYValue};
        ball_x_far    = ball_x + 10'(BALL_SIZE);
        ball_y_far    = ball_y + 10'(BALL_SIZE);
        lp_top        = {1'b0, leftPaddleY};
        rp_top        = {1'b0, rightPaddleY};
        lp_end        = lp_top + 10'(PADDLE_LENGTH);
        rp_end        = rp_top + 10'(PADDLE_LENGTH);
        at_right      = direction && (ball_x_far >= 10'(RIGHT_PADDLE_X));
        at_left       = !direction && (ball_x <= 10'(LEFT_PADDLE_X));
        overlap_left  = (ball_y_far > lp_top) && (ball_y < lp_end);
        overlap_right = (ball_y_far > rp_top) && (ball_y < rp_end);
        y_wall        = (ball_y == 10'd0) || (ball_y_far > 10'(SCREEN_Y_MAX));
        inside_field  = (10'(LEFT_PADDLE_X) < ball_x) &&
                        (ball_x_far < 10'(RIGHT_PADDLE_X));
        left_next     = leftScore + SCORE_WIDTH'(1);
        right_next    = rightScore + SCORE_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= PLAY;
            xcnt             <= '0;
            ycnt             <= '0;
            changeXDirection <= 1'b0;
            changeYDirection <= 1'b0;
            serveRequest     <= 1'b0;
            leftScore        <= '0;
            rightScore       <= '0;
            gameOver         <= 1'b0;
`ifdef RALLY_COUNT_EN
            rallyCount       <= '0;
`endif
        end else begin
            changeXDirection <= 1'b0;
            changeYDirection <= 1'b0;
            serveRequest     <= 1'b0;

            // Y walls run independently of the X state machine. A loaded
            // counter blocks re-triggering while the ball is still at the wall.
            if (state != GAME_OVER) begin
                if (ycnt != '0) begin
                    ycnt <= ycnt - CW'(1);
                end else if (y_wall) begin
                    changeYDirection <= 1'b1;
                    ycnt             <= CW'(COOLDOWN_CYCLES);
                end
            end

            case (state)
                PLAY: begin
                    if (at_right) begin
                        if (overlap_right) begin
                            changeXDirection <= 1'b1;
                            xcnt             <= '0;
                            state            <= X_COOL;
`ifdef RALLY_COUNT_EN
                            if (rallyCount != 8'hFF) rallyCount <= rallyCount + 8'd1;
`endif
                        end else begin
                            leftScore    <= left_next;
                            serveRequest <= 1'b1;
`ifdef RALLY_COUNT_EN
                            rallyCount   <= '0;
`endif
                            if (left_next == SCORE_WIDTH'(WIN_SCORE)) begin
                                gameOver <= 1'b1;
                                state    <= GAME_OVER;
                            end else begin
                                state    <= MISS;
                            end
                        end
                    end else if (at_left) begin
                        if (overlap_left) begin
                            changeXDirection <= 1'b1;
                            xcnt             <= '0;
                            state            <= X_COOL;
`ifdef RALLY_COUNT_EN
                            if (rallyCount != 8'hFF) rallyCount <= rallyCount + 8'd1;
`endif
                        end else begin
                            rightScore   <= right_next;
                            serveRequest <= 1'b1;
`ifdef RALLY_COUNT_EN
                            rallyCount   <= '0;
`endif
                            if (right_next == SCORE_WIDTH'(WIN_SCORE)) begin
                                gameOver <= 1'b1;
                                state    <= GAME_OVER;
                            end else begin
                                state    <= MISS;
                            end
                        end
                    end
                end
                X_COOL: begin
                    if (xcnt == CW'(COOLDOWN_CYCLES - 1)) state <= PLAY;
                    else xcnt <= xcnt + CW'(1);
                end
                MISS: begin
                    if (inside_field) state <= PLAY;
                end
                GAME_OVER: begin
                    state <= GAME_OVER;
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision_detect.sv
// Testbench for ball_collision_detect. Stimulus is applied on the falling
// edge. A reference model derived from the game rules predicts the outputs
// after the next rising edge and queues them. A monitor compares the queued
// prediction with the registered DUT outputs shortly after each rising edge.
module tb_ball_collision_detect;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] ballXValue;
    logic [8:0] ballYValue;
    logic       direction;
    logic [8:0] leftPaddleY;
    logic [8:0] rightPaddleY;
    logic       changeXDirection;
    logic       changeYDirection;
    logic       serveRequest;
    logic [3:0] leftScore;
    logic [3:0] rightScore;
    logic       gameOver;
`ifdef RALLY_COUNT_EN
    logic [7:0] rallyCount;
`endif

    ball_collision_detect dut (
        .clock            (clock),
        .reset            (reset),
        .ballXValue       (ballXValue),
        .ballYValue       (ballYValue),
        .direction        (direction),
        .leftPaddleY      (leftPaddleY),
        .rightPaddleY     (rightPaddleY),
        .changeXDirection (changeXDirection),
        .changeYDirection (changeYDirection),
        .serveRequest     (serveRequest),
        .leftScore        (leftScore),
        .rightScore       (rightScore),
        .gameOver         (gameOver)
`ifdef RALLY_COUNT_EN
        ,
        .rallyCount       (rallyCount)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int cx;
        int cy;
        int sr;
        int ls;
        int rs;
        int go;
        int rally;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state. The X cooldown is tracked as "edges left to wait".
    // The Y cooldown is tracked as "edges still blocked".
    // Modes: 0 in play, 1 cooling after a paddle hit, 2 waiting after a miss,
    // 3 game finished.
    int m_mode, m_xwait, m_yblock, m_ls, m_rs, m_go, m_rally;

    task automatic model_step(input int rst, input int x, input int y, input int dir,
                              input int lp, input int rp);
        exp_t e;
        e.cx = 0;
        e.cy = 0;
        e.sr = 0;
        if (rst != 0) begin
            m_mode = 0; m_xwait = 0; m_yblock = 0;
            m_ls = 0; m_rs = 0; m_go = 0; m_rally = 0;
        end else if (m_mode != 3) begin
            if (m_yblock > 0) m_yblock--;
            else if (y == 0 || y + 10 > 319) begin
                e.cy = 1;
                m_yblock = 4;
            end
            if (m_mode == 0) begin
                if (dir == 1 && x + 10 >= 219) begin
                    if (y + 10 > rp && y < rp + 50) begin
                        e.cx = 1; m_mode = 1; m_xwait = 4;
                        if (m_rally < 255) m_rally++;
                    end else begin
                        m_ls++; e.sr = 1; m_rally = 0;
                        m_mode = (m_ls == 9) ? 3 : 2;
                    end
                end else if (dir == 0 && x <= 10) begin
                    if (y + 10 > lp && y < lp + 50) begin
                        e.cx = 1; m_mode = 1; m_xwait = 4;
                        if (m_rally < 255) m_rally++;
                    end else begin
                        m_rs++; e.sr = 1; m_rally = 0;
                        m_mode = (m_rs == 9) ? 3 : 2;
                    end
                end
            end else if (m_mode == 1) begin
                m_xwait--;
                if (m_xwait == 0) m_mode = 0;
            end else if (m_mode == 2) begin
                if (x > 10 && x + 10 < 219) m_mode = 0;
            end
            if (m_mode == 3) m_go = 1;
        end
        e.ls = m_ls; e.rs = m_rs; e.go = m_go; e.rally = m_rally;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and queue the prediction.
    task automatic drive(input int rst, input int x, input int y, input int dir,
                         input int lp, input int rp);
        @(negedge clock);
        reset        = (rst != 0);
        ballXValue   = 8'(x);
        ballYValue   = 9'(y);
        direction    = (dir != 0);
        leftPaddleY  = 9'(lp);
        rightPaddleY = 9'(rp);
        model_step(rst, x, y, dir, lp, rp);
    endtask

    task automatic hold(input int n, input int x, input int y, input int dir,
                        input int lp, input int rp);
        for (int i = 0; i < n; i++) drive(0, x, y, dir, lp, rp);
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: the DUT presents registered outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("changeXDirection", int'(changeXDirection), e.cx);
                check("changeYDirection", int'(changeYDirection), e.cy);
                check("serveRequest", int'(serveRequest), e.sr);
                check("leftScore", int'(leftScore), e.ls);
                check("rightScore", int'(rightScore), e.rs);
                check("gameOver", int'(gameOver), e.go);
`ifdef RALLY_COUNT_EN
                check("rallyCount", int'(rallyCount), e.rally);
`endif
            end
        end
    end

    initial begin
        int x, y, dir, lp, rp, n, r, budget;
        reset = 1'b1; ballXValue = 8'd120; ballYValue = 9'd150; direction = 1'b1;
        leftPaddleY = 9'd100; rightPaddleY = 9'd100;

        // Reset for two cycles.
        drive(1, 120, 150, 1, 100, 100);
        drive(1, 120, 150, 1, 100, 100);
        hold(2, 120, 150, 1, 100, 100);

        // Right paddle hit held long enough to see the cooldown expire.
        hold(12, 209, 240, 1, 100, 220);
        hold(3, 120, 240, 0, 100, 220);

        // Right-side miss, then return to the field.
        hold(3, 209, 100, 1, 100, 220);
        hold(3, 120, 100, 1, 100, 220);

        // Corner hit on the left paddle at the top wall.
        drive(0, 10, 0, 0, 0, 100);
        hold(6, 120, 150, 1, 0, 100);

        // Bottom wall held so that the Y cooldown repeats.
        hold(12, 120, 310, 1, 100, 100);
        hold(5, 120, 150, 1, 100, 100);

        // Nine left-side misses end the game.
        for (int k = 0; k < 9; k++) begin
            hold(2, 5, 150, 0, 250, 100);
            hold(2, 120, 150, 0, 250, 100);
        end
        // Qualifying inputs after game over do nothing.
        hold(3, 5, 0, 0, 0, 100);
        hold(3, 209, 310, 1, 100, 300);
        drive(1, 120, 150, 1, 100, 100);
        hold(3, 120, 150, 1, 100, 100);

        // Randomized play with occasional resets.
        for (int k = 0; k < 700; k++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1: x = int'($urandom_range(200, 215));
                2, 3: x = int'($urandom_range(0, 14));
                default: x = int'($urandom_range(0, 245));
            endcase
            r = int'($urandom_range(0, 9));
            case (r)
                0: y = 0;
                1: y = int'($urandom_range(305, 319));
                default: y = int'($urandom_range(0, 319));
            endcase
            dir = int'($urandom_range(0, 1));
            lp  = int'($urandom_range(0, 280));
            rp  = int'($urandom_range(0, 280));
            n   = int'($urandom_range(1, 4));
            if ($urandom_range(0, 60) == 0) drive(1, x, y, dir, lp, rp);
            else hold(n, x, y, dir, lp, rp);
        end

        // Let the monitor drain the queue, within a bounded wait.
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
